// File: rtl/nes_poll_scheduler.sv
// nes_poll_scheduler: round-robin poll engine sharing one NES serial reader
// between two controller ports, fed by an auto-poll timer and per-port requests.
// Optional build macro: NES_EDGE_DETECT_EN adds press0/press1 (new-press masks).
//
// state  | meaning
// IDLE   | waiting for a pending port while en is high
// LATCH  | shared latch high for two ticks, bit 0 sampled on the last cycle
// CLK_HI | granted port shift clock high for one tick
// CLK_LO | shift clock low for one tick, next bit sampled on the last cycle
// DONE   | one cycle: publish snapshot, strobe valid, restart the poll timer
module nes_poll_scheduler #(
    parameter int CLK_DIV    = 300,
    parameter int POLL_TICKS = 1389
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] poll_req,
    input  logic [1:0] nes_d,
    output logic       nes_latch,
    output logic [1:0] nes_clk,
    output logic [7:0] btn0,
    output logic [7:0] btn1,
`ifdef NES_EDGE_DETECT_EN
    output logic [7:0] press0,
    output logic [7:0] press1,
`endif
    output logic [1:0] valid,
    output logic       busy
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PT_W  = $clog2(POLL_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PT_W-1:0]  PT_LAST  = PT_W'(POLL_TICKS - 1);

    typedef enum logic [2:0] {IDLE, LATCH, CLK_HI, CLK_LO, DONE} state_t;

    state_t           state, state_nx;
    logic [DIV_W-1:0] tick_cnt;
    logic [DIV_W-1:0] idle_div;
    logic [PT_W-1:0]  poll_cnt;
    logic             poll_hold;
    logic             gnt;
    logic             last;
    logic [1:0]       pending, pend_nx;
    logic [2:0]       bit_cnt;
    logic [7:0]       sr, sr_nx;
    logic             grant, grant_port;
    logic             shift_now, word_done;
    logic             tick_end, idle_tick, poll_fire;

    assign tick_end  = (tick_cnt == DIV_LAST);
    // The idle prescaler is separate because the sequence tick counter is frozen in IDLE.
    assign idle_tick = (state == IDLE) && en && !poll_hold && (idle_div == DIV_LAST);
    assign poll_fire = idle_tick && (poll_cnt == PT_LAST);
    // Controller data is active-low; the snapshot is active-high, first bit ends up in [0].
    assign sr_nx     = {~nes_d[gnt], sr[7:1]};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state, arbitration and sampling strobes.
    always_comb begin
        state_nx   = state;
        grant      = 1'b0;
        grant_port = gnt;
        shift_now  = 1'b0;
        word_done  = 1'b0;
        case (state)
            IDLE: begin
                if (en && (pending != 2'b00)) begin
                    grant      = 1'b1;
                    grant_port = (pending == 2'b11) ? ~last : pending[1];
                    state_nx   = LATCH;
                end
            end
            LATCH: begin
                if (tick_end && (bit_cnt == 3'd1)) begin
                    shift_now = 1'b1;
                    state_nx  = CLK_HI;
                end
            end
            CLK_HI: begin
                if (tick_end) state_nx = CLK_LO;
            end
            CLK_LO: begin
                if (tick_end) begin
                    shift_now = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        word_done = 1'b1;
                        state_nx  = DONE;
                    end else begin
                        state_nx = CLK_HI;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Pending bits: a request arriving in the grant cycle is kept, not lost.
    always_comb begin
        pend_nx = pending | poll_req;
        if (grant)     pend_nx[grant_port] = poll_req[grant_port];
        if (poll_fire) pend_nx[~last]      = 1'b1;
    end

    // Sequence datapath: granted port, tick counter, bit index, shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt      <= 1'b0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
        end else begin
            if (grant) begin
                gnt      <= grant_port;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else if (state != IDLE) begin
                tick_cnt <= tick_end ? '0 : tick_cnt + DIV_W'(1);
                // In LATCH bit_cnt counts the two latch ticks, then doubles as the bit index.
                if (state == LATCH && tick_end)
                    bit_cnt <= 3'd1;
                else if (state == CLK_LO && tick_end && bit_cnt != 3'd7)
                    bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_now) sr <= sr_nx;
        end
    end

    // Auto-poll timer, pending bits and round-robin history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_div  <= '0;
            poll_cnt  <= '0;
            poll_hold <= 1'b0;
            pending   <= 2'b00;
            last      <= 1'b1;
        end else begin
            pending <= pend_nx;
            if (state == DONE) begin
                last      <= gnt;
                idle_div  <= '0;
                poll_cnt  <= '0;
                poll_hold <= 1'b0;
            end else if ((state == IDLE) && en && !poll_hold) begin
                if (idle_tick) begin
                    idle_div <= '0;
                    if (poll_fire) begin
                        poll_cnt  <= '0;
                        poll_hold <= 1'b1;
                    end else begin
                        poll_cnt <= poll_cnt + PT_W'(1);
                    end
                end else begin
                    idle_div <= idle_div + DIV_W'(1);
                end
            end
        end
    end

    // Registered pin and consumer outputs, decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nes_latch <= 1'b0;
            nes_clk   <= 2'b00;
            busy      <= 1'b0;
            valid     <= 2'b00;
            btn0      <= 8'h00;
            btn1      <= 8'h00;
`ifdef NES_EDGE_DETECT_EN
            press0    <= 8'h00;
            press1    <= 8'h00;
`endif
        end else begin
            nes_latch <= (state_nx == LATCH);
            busy      <= (state_nx != IDLE);
            nes_clk   <= (state_nx == CLK_HI) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
            valid     <= word_done ? (gnt ? 2'b10 : 2'b01) : 2'b00;
            if (word_done && !gnt) btn0 <= sr_nx;
            if (word_done && gnt)  btn1 <= sr_nx;
`ifdef NES_EDGE_DETECT_EN
            press0    <= (word_done && !gnt) ? (sr_nx & ~btn0) : 8'h00;
            press1    <= (word_done && gnt)  ? (sr_nx & ~btn1) : 8'h00;
`endif
        end
    end

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// Testbench for nes_poll_scheduler with CLK_DIV=4, POLL_TICKS=10.
// Two behavioural NES controllers drive nes_d from per-port pressed patterns.
module tb_nes_poll_scheduler;

    localparam int CLK_DIV    = 4;
    localparam int POLL_TICKS = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [1:0] poll_req = 2'b00;
    wire  [1:0] nes_d;
    logic       nes_latch;
    logic [1:0] nes_clk;
    logic [7:0] btn0, btn1;
    logic [1:0] valid;
    logic       busy;
`ifdef NES_EDGE_DETECT_EN
    logic [7:0] press0, press1;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] pat0 = 8'h00;
    logic [7:0] pat1 = 8'h00;
    int idx0 = 8;
    int idx1 = 8;

    nes_poll_scheduler #(.CLK_DIV(CLK_DIV), .POLL_TICKS(POLL_TICKS)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .poll_req(poll_req),
        .nes_d(nes_d),
        .nes_latch(nes_latch),
        .nes_clk(nes_clk),
        .btn0(btn0),
        .btn1(btn1),
`ifdef NES_EDGE_DETECT_EN
        .press0(press0),
        .press1(press1),
`endif
        .valid(valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Controller models: latch loads bit 0, each shift-clock rise advances one bit.
    always @(posedge nes_latch or posedge nes_clk[0]) begin
        if (nes_latch) idx0 = 0;
        else           idx0 = idx0 + 1;
    end
    always @(posedge nes_latch or posedge nes_clk[1]) begin
        if (nes_latch) idx1 = 0;
        else           idx1 = idx1 + 1;
    end
    wire d0 = (idx0 < 8) ? ~pat0[idx0[2:0]] : 1'b0;
    wire d1 = (idx1 < 8) ? ~pat1[idx1[2:0]] : 1'b0;
    assign nes_d = {d1, d0};

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name, output logic [1:0] v, output int at);
        bit found;
        found = 1'b0;
        v = 2'b00;
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (valid != 2'b00) begin
                v = valid;
                at = cyc;
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for valid actual=none required=strobe", name);
        end
    endtask

    task automatic pulse_req(input logic [1:0] r);
        @(negedge clk);
        poll_req = r;
        @(negedge clk);
        poll_req = 2'b00;
    endtask

    task automatic run_req(input string name, input logic [1:0] r, output logic [1:0] v, output int at);
        pulse_req(r);
        en = 1'b1;
        wait_valid(name, v, at);
        en = 1'b0;
    endtask

    typedef struct packed {
        logic [1:0] req;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [1:0] ev;
        logic [7:0] eb0;
        logic [7:0] eb1;
    } vec_t;

    vec_t vecs [0:5];

    logic [69:0] w_lat, w_c0, w_c1, w_v0, w_v1, w_busy;
    logic [69:0] e_lat, e_c0, e_v0, e_busy;
    logic [7:0]  b_pre, b_at;
    logic [1:0]  v;
    int          n, at1, at2, lat_seen;

    initial begin
        vecs[0] = '{req: 2'b01, p0: 8'hFF, p1: 8'h00, ev: 2'b01, eb0: 8'hFF, eb1: 8'h00};
        vecs[1] = '{req: 2'b10, p0: 8'h00, p1: 8'h81, ev: 2'b10, eb0: 8'hFF, eb1: 8'h81};
        vecs[2] = '{req: 2'b01, p0: 8'h00, p1: 8'hFF, ev: 2'b01, eb0: 8'h00, eb1: 8'h81};
        vecs[3] = '{req: 2'b10, p0: 8'hFF, p1: 8'h7E, ev: 2'b10, eb0: 8'h00, eb1: 8'h7E};
        vecs[4] = '{req: 2'b01, p0: 8'h3C, p1: 8'h00, ev: 2'b01, eb0: 8'h3C, eb1: 8'h7E};
        vecs[5] = '{req: 2'b10, p0: 8'h00, p1: 8'hC3, ev: 2'b10, eb0: 8'h3C, eb1: 8'hC3};

        // Reset state.
        #12;
        check("rst_latch", nes_latch, 1'b0);
        check("rst_clk", nes_clk, 2'b00);
        check("rst_btn0", btn0, 8'h00);
        check("rst_btn1", btn1, 8'h00);
        check("rst_valid", valid, 2'b00);
        check("rst_busy", busy, 1'b0);

        // Auto-poll of port 0 after 10 idle ticks, full waveform for one sequence.
        pat0 = 8'h5A;
        @(negedge clk);
        reset = 1'b1;
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (nes_latch) break;
        end
        check("autopoll_delay_in_range", (n >= 40 && n <= 42), 1'b1);
        b_pre = 8'hxx;
        b_at = 8'hxx;
        for (int k = 0; k < 70; k++) begin
            w_lat[k]  = nes_latch;
            w_c0[k]   = nes_clk[0];
            w_c1[k]   = nes_clk[1];
            w_v0[k]   = valid[0];
            w_v1[k]   = valid[1];
            w_busy[k] = busy;
            e_lat[k]  = (k < 8);
            e_c0[k]   = (k >= 8) && (k < 64) && (((k - 8) % 8) < 4);
            e_v0[k]   = (k == 64);
            e_busy[k] = (k <= 64);
            if (k == 63) b_pre = btn0;
            if (k == 64) b_at = btn0;
            @(negedge clk);
        end
        en = 1'b0;
        check("wave_latch", w_lat, e_lat);
        check("wave_clk0", w_c0, e_c0);
        check("wave_clk1", w_c1, 70'd0);
        check("wave_valid0", w_v0, e_v0);
        check("wave_valid1", w_v1, 70'd0);
        check("wave_busy", w_busy, e_busy);
        check("btn0_before_done", b_pre, 8'h00);
        check("btn0_at_done", b_at, 8'h5A);

        // Table of single-port requests.
        for (int i = 0; i < 6; i++) begin
            pat0 = vecs[i].p0;
            pat1 = vecs[i].p1;
            run_req($sformatf("vec%0d", i), vecs[i].req, v, at1);
            check($sformatf("vec%0d_valid", i), v, vecs[i].ev);
            check($sformatf("vec%0d_btn0", i), btn0, vecs[i].eb0);
            check($sformatf("vec%0d_btn1", i), btn1, vecs[i].eb1);
            @(negedge clk);
            check($sformatf("vec%0d_valid_once", i), valid, 2'b00);
        end

        // Both ports requested together with last=1: port 0 then port 1, one idle cycle apart.
        pat0 = 8'h12;
        pat1 = 8'h34;
        pulse_req(2'b11);
        en = 1'b1;
        wait_valid("both_first", v, at1);
        check("both_first_valid", v, 2'b01);
        check("both_first_btn0", btn0, 8'h12);
        @(negedge clk);
        check("both_gap_busy", busy, 1'b0);
        wait_valid("both_second", v, at2);
        check("both_second_valid", v, 2'b10);
        check("both_second_btn1", btn1, 8'h34);
        check("both_interval", at2 - at1, 66);
        en = 1'b0;

        // Request for port 1 during port 0's sequence: granted right after DONE.
        pat0 = 8'h55;
        pat1 = 8'hAA;
        pulse_req(2'b01);
        en = 1'b1;
        repeat (20) @(negedge clk);
        poll_req = 2'b10;
        @(negedge clk);
        poll_req = 2'b00;
        wait_valid("mid_first", v, at1);
        check("mid_first_valid", v, 2'b01);
        check("mid_first_btn0", btn0, 8'h55);
        @(negedge clk);
        check("mid_grant_cycle_latch", nes_latch, 1'b0);
        @(negedge clk);
        check("mid_next_latch", nes_latch, 1'b1);
        wait_valid("mid_second", v, at2);
        check("mid_second_valid", v, 2'b10);
        check("mid_second_btn1", btn1, 8'hAA);
        en = 1'b0;

        // en dropped mid-sequence with port 1 pending.
        pat0 = 8'h0F;
        pat1 = 8'hF0;
        pulse_req(2'b01);
        en = 1'b1;
        repeat (10) @(negedge clk);
        poll_req = 2'b10;
        @(negedge clk);
        poll_req = 2'b00;
        en = 1'b0;
        wait_valid("endrop_first", v, at1);
        check("endrop_first_valid", v, 2'b01);
        check("endrop_first_btn0", btn0, 8'h0F);
        lat_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (nes_latch) lat_seen++;
        end
        check("endrop_no_grant", lat_seen, 0);
        check("endrop_idle_busy", busy, 1'b0);
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("endrop_resume_latch", nes_latch, 1'b1);
        wait_valid("endrop_second", v, at2);
        check("endrop_second_valid", v, 2'b10);
        check("endrop_second_btn1", btn1, 8'hF0);
        en = 1'b0;

        // Asynchronous reset during CLK_HI, then port 0 is served first.
        pat0 = 8'hE7;
        pulse_req(2'b01);
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (nes_clk[0]) break;
            n++;
        end
        check("rstmid_reached_clk_hi", nes_clk, 2'b01);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_clk", nes_clk, 2'b00);
        check("rstmid_latch", nes_latch, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_btn0", btn0, 8'h00);
        check("rstmid_btn1", btn1, 8'h00);
        check("rstmid_valid", valid, 2'b00);
        en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        pat0 = 8'h99;
        pat1 = 8'h66;
        pulse_req(2'b11);
        en = 1'b1;
        wait_valid("post_rst_first", v, at1);
        check("post_rst_first_valid", v, 2'b01);
        check("post_rst_btn0", btn0, 8'h99);
        wait_valid("post_rst_second", v, at2);
        check("post_rst_second_valid", v, 2'b10);
        check("post_rst_btn1", btn1, 8'h66);
        en = 1'b0;

`ifdef NES_EDGE_DETECT_EN
        // New-press mask: 0x01 -> 0x03 reports only bit 1, for the DONE cycle only.
        pat0 = 8'h01;
        run_req("edge_first", 2'b01, v, at1);
        check("edge_first_btn0", btn0, 8'h01);
        pat0 = 8'h03;
        run_req("edge_second", 2'b01, v, at2);
        check("edge_btn0", btn0, 8'h03);
        check("edge_press0", press0, 8'h02);
        check("edge_press1", press1, 8'h00);
        @(negedge clk);
        check("edge_press0_after", press0, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nes_poll_scheduler.md
# nes_poll_scheduler

Round-robin poll scheduler that shares one NES serial-read engine between two controller ports. It drives the shared latch line and a per-port shift clock, deserializes the 8 button bits, and publishes a per-port button snapshot with a valid strobe. Requests come from a periodic auto-poll timer or from explicit per-port requests from game logic. It sits between the board-level NES controller pins and the downstream button consumers, replacing ad-hoc single-port driving.

## Interface
- `CLK_DIV`, 300: `clk` cycles per tick (6 us at 50 MHz); minimum 2.
- `POLL_TICKS`, 1389: ticks from the end of one sequence to the next auto-request (≈60 Hz per port); minimum 1.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: high enables new sequences and the auto-poll timer.
- `poll_req` in 2: one-cycle request pulse per port, bit i = port i.
- `nes_d` in 2: serial data from ports 0/1; active-low (0 = pressed).
- `nes_latch` out 1: shared latch, active-high.
- `nes_clk` out 2: per-port shift clock; idles low.
- `btn0`, `btn1` out 8: snapshot, active-high pressed; bit order [0]A [1]B [2]SEL [3]STRT [4]UP [5]DN [6]L [7]R.
- `valid` out 2: one-cycle strobe, bit i high when `btn<i>` updates.
- `busy` out 1: high while a sequence is in progress.

## Operation
- Each port has a sticky `pending` bit.
  - Set by `poll_req[i]` in any state.
  - Set by timer expiry for port `~last`.
  - Cleared when that port's sequence is granted.
- Arbitration happens only in IDLE, with `en`=1 and any pending bit set.
  - If exactly one bit is pending, grant that port.
  - If both are pending, grant port `~last`.
  - `last` resets to 1, so port 0 is served first.
- FSM states: IDLE → LATCH → CLK_HI → CLK_LO → DONE → IDLE.
  - LATCH: `nes_latch`=1 for 2 ticks. At the final cycle, sample `~nes_d[g]` into bit 0.
  - CLK_HI: `nes_clk[g]`=1 for 1 tick.
  - CLK_LO: `nes_clk[g]`=0 for 1 tick. At its final cycle, sample the next bit (1..7).
  - CLK_LO → CLK_HI repeats until 7 bits have been shifted after the latch, then goes to DONE.
  - DONE: one cycle. Load the shift register into `btn<g>`, pulse `valid[g]`, set `last`=g, restart the poll timer.
- `nes_clk` of the non-granted port stays 0 throughout.
- The tick counter (width `$clog2(CLK_DIV)`) clears on grant and counts only outside IDLE.
- Poll timer (width `$clog2(POLL_TICKS+1)`):
  - Counts ticks while `en`=1 and the FSM is in IDLE.
  - On reaching `POLL_TICKS` it sets `pending[~last]` and holds at zero until the next DONE.
- `en` deasserted mid-sequence: the sequence completes normally. Afterwards no grant occurs and pending bits are retained.
- `poll_req` for the port currently being served sets `pending` again; that port is polled again later, subject to round-robin.
- Reset (any time, asynchronous):
  - `nes_latch`=0, `nes_clk`=0, `btn0`=`btn1`=0, `valid`=0, `busy`=0.
  - `pending`=0, `last`=1, FSM in IDLE, counters cleared.
  - A partially shifted word is discarded.

## Timing
- Grant at cycle t (IDLE): `nes_latch` and `busy` rise at t+1, registered.
- `nes_latch` is high for exactly 2·`CLK_DIV` cycles.
- First `nes_clk` rise is at t+1+2·`CLK_DIV`. The 7 pulses each last `CLK_DIV` high and `CLK_DIV` low.
- `valid[g]` and the new `btn<g>` appear at t+1+16·`CLK_DIV`, in the DONE cycle.
- `busy` falls at t+2+16·`CLK_DIV`.
- Earliest next grant is the cycle after DONE, i.e. back-to-back sequences have a one-cycle IDLE gap.
- All outputs are registered; none depends combinationally on an input.

## Configuration
- `NES_EDGE_DETECT_EN` defined: adds outputs `press0` and `press1` (out 8 each).
  - In the DONE cycle for port g, `press<g>` = new & ~old `btn<g>`.
  - Otherwise `press<g>` = 0; reset value 0.
- Not defined: the ports and their registers are absent. All other behaviour is identical.

## Test plan
- `CLK_DIV`=4, `POLL_TICKS`=10. Release reset, `en`=1, `nes_d[0]` serial stream gives active-low 0b1010_0101 → after 10 ticks:
  - `nes_latch` high 8 cycles, then 7 `nes_clk[0]` pulses of 4 high / 4 low; `nes_clk[1]` stays 0.
  - `btn0`=8'h5A, with `valid[0]` exactly 1 cycle, 64 cycles after the latch rise.
- `poll_req`=2'b11 in the same cycle while IDLE, `last`=1 → port 0 served, then port 1 with one idle cycle between; `valid` pulses 2'b01 then 2'b10.
- `poll_req[1]` pulsed mid-sequence of port 0 → port 1 is granted in the cycle after port 0's DONE.
- `reset` asserted during CLK_HI → `nes_clk`, `nes_latch`, `busy` and `btn` are 0 immediately. After release, the first sequence goes to port 0.
- `en` dropped during a port 0 sequence with `pending[1]` set → port 0 completes with `valid[0]`; port 1 is not granted until `en`=1, then granted the next cycle.
- `NES_EDGE_DETECT_EN` defined: `btn0` goes 8'h01 → 8'h03 → `press0`=8'h02 for exactly the DONE cycle, 0 otherwise.
